rgb_to_colour_decoder: RTL and testbench

- Inverse of the team's 3-bit colour → 24-bit RGB converter: classifies a streamed 24-bit RGB pixel back to the nearest 3-bit palette code.
- Palette encoding is colour[2]=R, colour[1]=G, colour[0]=B; exact palette words are 00/FF per channel (0=000000, 1=0000FF, 2=00FF00, 3=00FFFF, 4=FF0000, 5=FF00FF, 6=FFFF00, 7=FFFFFF).
- 2-stage pipeline with valid/ready on both sides, so it can be chained directly behind the converter for loopback checking.

---
 rtl/rgb_to_colour_decoder.sv | 81 ++++++++
 tb/tb_rgb_to_colour_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rgb_to_colour_decoder.sv
// rgb_to_colour_decoder: 2-stage valid/ready classifier of 24-bit RGB pixels to 3-bit palette codes.
// Define INEXACT_CNT_EN to build the saturating inexact-pixel counter; otherwise inexact_cnt is 0.
module rgb_to_colour_decoder #(
    parameter logic [7:0]  THRESH = 8'h80,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [23:0]      rgb,
    input  logic             rgb_valid,
    output logic             rgb_ready,
    output logic [2:0]       colour,
    output logic             exact,
    output logic             colour_valid,
    input  logic             colour_ready,
    output logic [CNT_W-1:0] inexact_cnt
);
    logic       s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [2:0] c1_q, c1_d, colour_q, colour_d;
    logic       e1_q, e1_d, exact_q, exact_d;
    logic       adv1, adv2, in_xfer, e_in;
    logic [2:0] c_in;

    function automatic logic ch_exact(input logic [7:0] c);
        return c == 8'h00 || c == 8'hFF;
    endfunction

    always_comb begin
        adv2       = !s2_valid_q || colour_ready;
        adv1       = !s1_valid_q || adv2;
        in_xfer    = rgb_valid && enable && adv1;
        c_in       = {rgb[23:16] >= THRESH, rgb[15:8] >= THRESH, rgb[7:0] >= THRESH};
        e_in       = ch_exact(rgb[23:16]) && ch_exact(rgb[15:8]) && ch_exact(rgb[7:0]);
        s1_valid_d = in_xfer ? 1'b1 : (adv1 ? 1'b0 : s1_valid_q);
        c1_d       = in_xfer ? c_in : c1_q;
        e1_d       = in_xfer ? e_in : e1_q;
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        colour_d   = adv2 ? c1_q : colour_q;
        exact_d    = adv2 ? e1_q : exact_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            c1_q       <= 3'd0;
            e1_q       <= 1'b0;
            colour_q   <= 3'd0;
            exact_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            c1_q       <= c1_d;
            e1_q       <= e1_d;
            colour_q   <= colour_d;
            exact_q    <= exact_d;
        end
    end

    assign rgb_ready    = enable && adv1;
    assign colour       = colour_q;
    assign exact        = exact_q;
    assign colour_valid = s2_valid_q;

`ifdef INEXACT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at all-ones rather than wrapping.
    always_comb cnt_d = (in_xfer && !e_in && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign inexact_cnt = cnt_q;
`else
    assign inexact_cnt = '0;
`endif
endmodule

// File: tb/tb_rgb_to_colour_decoder.sv
// tb_rgb_to_colour_decoder: randomized + directed check against a queue-based reference model.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_rgb_to_colour_decoder;
    localparam logic [7:0] TH = 8'h80;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, rgb_valid = 1'b0, colour_ready = 1'b0;
    logic [23:0] rgb = 24'd0;
    logic        rgb_ready, exact, colour_valid, rgb_ready2, exact2, colour_valid2;
    logic [2:0]  colour, colour2;
    logic [15:0] inexact_cnt;
    logic [1:0]  inexact_cnt2;

    int n_vec = 0, n_err = 0;
    int cnt16 = 0, cnt2 = 0;

    typedef struct {
        logic [2:0] c;
        logic       e;
        int         age;
    } item_t;
    item_t q[$];

    rgb_to_colour_decoder #(.THRESH(TH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rgb(rgb), .rgb_valid(rgb_valid),
        .rgb_ready(rgb_ready), .colour(colour), .exact(exact), .colour_valid(colour_valid),
        .colour_ready(colour_ready), .inexact_cnt(inexact_cnt)
    );

    rgb_to_colour_decoder #(.THRESH(TH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .rgb(rgb), .rgb_valid(rgb_valid),
        .rgb_ready(rgb_ready2), .colour(colour2), .exact(exact2), .colour_valid(colour_valid2),
        .colour_ready(colour_ready), .inexact_cnt(inexact_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_colour(input logic [23:0] p);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = p[8*i +: 8] >= TH;
        return r;
    endfunction

    function automatic logic ref_exact(input logic [23:0] p);
        logic r = 1'b1;
        for (int i = 0; i < 3; i++) r &= (p[8*i +: 8] == 8'h00) || (p[8*i +: 8] == 8'hFF);
        return r;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef INEXACT_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic step(input logic en, input logic v, input logic [23:0] px, input logic cr);
        logic mr, mv, acc, pop;
        enable = en; rgb_valid = v; rgb = px; colour_ready = cr;
        #1;
        mv = q.size() > 0 && q[0].age >= 1;
        mr = en && (q.size() < 2 || cr);
        check("rgb_ready", 32'(rgb_ready), 32'(mr));
        check("rgb_ready2", 32'(rgb_ready2), 32'(mr));
        check("colour_valid", 32'(colour_valid), 32'(mv));
        check("colour_valid2", 32'(colour_valid2), 32'(mv));
        if (mv) begin
            check("colour", 32'(colour), 32'(q[0].c));
            check("exact", 32'(exact), 32'(q[0].e));
            check("colour2", 32'(colour2), 32'(q[0].c));
            check("exact2", 32'(exact2), 32'(q[0].e));
        end
        check("inexact_cnt", 32'(inexact_cnt), 32'(exp_cnt(cnt16)));
        check("inexact_cnt2", 32'(inexact_cnt2), 32'(exp_cnt(cnt2)));
        acc = v && mr;
        pop = mv && cr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
            q.push_back('{ref_colour(px), ref_exact(px), 0});
            if (!ref_exact(px)) begin
                cnt16 = cnt16 < 65535 ? cnt16 + 1 : cnt16;
                cnt2  = cnt2 < 3 ? cnt2 + 1 : cnt2;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rgb_valid = 1'b1; enable = 1'b1; colour_ready = 1'b0;
        @(posedge clk);
        q.delete();
        cnt16 = 0; cnt2 = 0;
        @(negedge clk);
        check("rst_colour_valid", 32'(colour_valid), 32'(0));
        check("rst_colour", 32'(colour), 32'(0));
        check("rst_exact", 32'(exact), 32'(0));
        check("rst_cnt", 32'(inexact_cnt), 32'(0));
        rst = 1'b0;
    endtask

    function automatic logic [23:0] rand_px();
        logic [23:0] p;
        int m = $urandom_range(0, 3);
        if (m == 0) begin
            for (int i = 0; i < 3; i++) p[8*i +: 8] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        end else if (m == 1) begin
            for (int i = 0; i < 3; i++) p[8*i +: 8] = $urandom_range(0, 1) ? TH : TH - 8'd1;
        end else begin
            p = 24'($urandom);
        end
        return p;
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1, 1, {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}}, 1);
        repeat (3) step(1, 0, 24'd0, 1);
        step(1, 1, 24'h807F80, 1);
        step(1, 1, 24'h7F807F, 1);
        repeat (3) step(1, 0, 24'd0, 1);
        step(1, 1, 24'hFF0000, 0);
        step(1, 1, 24'h00FF00, 0);
        repeat (3) step(1, 1, 24'h0000FF, 0);
        step(1, 1, 24'h0000FF, 1);
        repeat (4) step(1, 0, 24'd0, 1);
        step(1, 1, 24'h00FFFF, 0);
        step(1, 1, 24'hFFFF00, 0);
        repeat (4) step(0, 1, 24'hFFFFFF, 1);
        step(1, 1, 24'hFFFFFF, 1);
        repeat (3) step(1, 0, 24'd0, 1);
        step(1, 1, 24'hFF00FF, 0);
        step(1, 1, 24'h00FF00, 0);
        do_reset();
        repeat (3) step(1, 0, 24'd0, 1);
        repeat (5) step(1, 1, 24'h101010, 1);
        repeat (3) step(1, 0, 24'd0, 1);
        do_reset();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rand_px(), $urandom_range(0, 9) < 7);
        repeat (4) step(1, 0, 24'd0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
